// File: rtl/mod_add_256.sv
// mod_add_256: registered modular adder, R = (A + B) mod P.
//
// Field-addition primitive for the ECDSA point-arithmetic datapath. It accepts one
// operand pair per clock and has no backpressure. out_valid is in_valid delayed by
// the pipeline latency.
//
// Build option:
//   MOD_ADD_PIPE_EN  When defined, a second register stage holds the sum and the
//                    valid bit, and the latency becomes 2. When undefined, the block
//                    has one stage and a latency of 1. R is the same in both builds.
//
// Parameters:
//   W  operand and result width in bits (default 256)
//   P  odd modulus with 2^(W-1) < P < 2^W (default: the secp256k1 field prime)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every pipeline register
//   in_valid   A and B are sampled this cycle
//   A, B       addends, expected in 0..P-1 (out-of-range inputs are not flagged)
//   out_valid  R holds a new result this cycle
//   R          registered result; it keeps its value between valid results
module mod_add_256 #(
  parameter int unsigned  W = 256,
  parameter logic [W-1:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  output logic [W-1:0] R
);

  // Full sum with its carry. For in-range inputs this is below 2P.
  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, A} + {1'b0, B};
  end

  // Sum and valid as seen by the reduction stage.
  logic [W:0] stage_sum;
  logic       stage_valid;

`ifdef MOD_ADD_PIPE_EN
  logic [W:0] sum_q;
  logic       valid1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum;
      end
    end
  end

  assign stage_sum   = sum_q;
  assign stage_valid = valid1_q;
`else
  assign stage_sum   = sum;
  assign stage_valid = in_valid;
`endif

  // Single conditional subtraction. The borrow of the (W+2)-bit difference S - P is
  // the same as S < P. The low W bits of that difference are the W-bit wrap-around
  // of S - P, so the subtractor only needs to be W bits wide. When S == P, the
  // result is 0.
  logic         borrow;
  logic [W-1:0] r_d;

  always_comb begin
    borrow = (stage_sum < {1'b0, P});
    r_d    = borrow ? stage_sum[W-1:0] : (stage_sum[W-1:0] - P);
  end

  logic [W-1:0] r_q;
  logic         out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= stage_valid;
      // R is loaded only with new results, so it holds steady while the input is idle.
      if (stage_valid) begin
        r_q <= r_d;
      end
    end
  end

  assign R         = r_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mod_add_256.sv
// tb_mod_add_256: directed self-checking bench for mod_add_256.
// The bench uses the same MOD_ADD_PIPE_EN define as the DUT and sets its expected
// latency to match.
module tb_mod_add_256;

  localparam int unsigned W = 256;
`ifdef MOD_ADD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [W-1:0] P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [W-1:0] PM1 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;
  localparam logic [W-1:0] PM2 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] r;

  int n_checks = 0;
  int n_errors = 0;

  mod_add_256 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .R         (r)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one pair, then check the latency, the result and that R holds afterwards.
  task automatic run_one(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] exp);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~av;  // changing A/B while idle must not disturb R
    b = ~bv;
    for (int i = 1; i < LAT; i++) begin
      check_eq({tag, "/early_valid"}, W'(out_valid), W'(0));
      step();
    end
    check_eq({tag, "/valid"}, W'(out_valid), W'(1));
    check_eq({tag, "/R"}, r, exp);
    step();
    check_eq({tag, "/valid_drop"}, W'(out_valid), W'(0));
    check_eq({tag, "/R_hold"}, r, exp);
  endtask

  logic [W-1:0] s_a [4];
  logic [W-1:0] s_b [4];
  logic [W-1:0] s_e [4];

  initial begin
    #2;
    check_eq("reset/valid", W'(out_valid), W'(0));
    check_eq("reset/R", r, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_one("zero", '0, '0, '0);
    run_one("one_one", W'(1), W'(1), W'(2));
    run_one("no_wrap", W'(32'h1234), W'(32'hFEDC), W'(32'h11110));
    run_one("pm1_1", PM1, W'(1), '0);
    run_one("pm2_3", PM2, W'(3), W'(1));
    run_one("pm1_pm1", PM1, PM1, PM2);
    run_one("pm1_0", PM1, '0, PM1);
    run_one("p_0_oor", P, '0, '0);
    run_one("all1_oor", ALL1, ALL1, W'(40'h1_000003CF));
    run_one("msb_msb", MSB, MSB, W'(40'h1_000003D1));

    // Streaming: four pairs on back-to-back cycles.
    s_a[0] = PM1; s_b[0] = W'(1); s_e[0] = '0;
    s_a[1] = PM2; s_b[1] = W'(3); s_e[1] = W'(1);
    s_a[2] = PM1; s_b[2] = PM1;   s_e[2] = PM2;
    s_a[3] = PM1; s_b[3] = '0;    s_e[3] = PM1;
    for (int c = 0; c < 4 + LAT + 1; c++) begin
      if (c < 4) begin
        a = s_a[c];
        b = s_b[c];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        a = '0;
        b = '0;
      end
      step();
      begin
        int idx;
        idx = c + 1 - LAT;
        if (idx < 0) begin
          check_eq($sformatf("stream/pre_valid%0d", c), W'(out_valid), W'(0));
        end else if (idx < 4) begin
          check_eq($sformatf("stream/valid%0d", idx), W'(out_valid), W'(1));
          check_eq($sformatf("stream/R%0d", idx), r, s_e[idx]);
        end else begin
          check_eq($sformatf("stream/idle_valid%0d", c), W'(out_valid), W'(0));
          check_eq($sformatf("stream/idle_R%0d", c), r, s_e[3]);
        end
      end
    end

    // Reset while results are in flight.
    a = W'(1); b = W'(1); in_valid = 1'b1;
    step();
    a = W'(2); b = W'(2);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst/valid", W'(out_valid), W'(0));
    check_eq("midrst/R", r, '0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      check_eq($sformatf("midrst/no_stale%0d", i), W'(out_valid), W'(0));
    end
    run_one("after_rst", W'(5), W'(6), W'(11));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
